// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the UART command receiver.
//   rx_state_t    - receiver FSM state encoding
//   CMD_MAX_INDEX - highest byte value that maps directly onto a decoder index
//   CMD_CLEAR     - byte that clears every virtual button/switch
//   CLEAR_NUMBER  - out-of-range decoder index that resets all decoder outputs
//   is_valid_cmd  - true for bytes the receiver accepts as commands
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH,
    ST_EMIT
  } rx_state_t;

  localparam logic [7:0] CMD_MAX_INDEX = 8'h15;
  localparam logic [7:0] CMD_CLEAR     = 8'h7F;
  localparam logic [4:0] CLEAR_NUMBER  = 5'b11111;

  function automatic logic is_valid_cmd(input logic [7:0] cmd_byte);
    return (cmd_byte <= CMD_MAX_INDEX) || (cmd_byte == CMD_CLEAR);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 byte receiver with 16x oversampling.
//   clk         - system clock, rising edge
//   rst_n       - synchronous active-low reset
//   rx          - asynchronous serial line, idles high
//   emit_done   - top level has finished handling the received byte
//   byte_valid  - one-cycle flag, high on the stop-bit sample tick of a good frame
//   byte_data   - received byte, valid while byte_valid is high
//   frame_error - one-cycle pulse when the stop bit samples low
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | line idle, waiting for a falling edge on rxs
// ST_START     | counting 8 ticks to the middle of the start bit
// ST_DATA      | sampling 8 data bits, LSB first, every 16 ticks
// ST_STOP      | sampling the stop bit after 16 ticks
// ST_WAIT_HIGH | framing error seen, waiting for the line to return high
// ST_EMIT      | byte handed to the top level, rx ignored until emit_done
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       emit_done,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
);

  localparam int          DIV      = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  rx_state_t   state;
  logic        rx_meta;
  logic        rxs;
  logic [15:0] div_cnt;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_idx;
  logic        tick;
  logic        sample_pt;

  assign tick      = (div_cnt == DIV_LAST);
  assign sample_pt = tick && (tick_cnt == 4'd15);
  // Combinational so the top can register number in the same cycle as the
  // stop sample, which puts the control rise two cycles after that tick.
  assign byte_valid = (state == ST_STOP) && sample_pt && rxs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      div_cnt     <= '0;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      byte_data   <= '0;
      frame_error <= 1'b0;
      state       <= ST_IDLE;
    end else begin
      rx_meta     <= rx;
      rxs         <= rx_meta;
      frame_error <= 1'b0;
      div_cnt     <= tick ? '0 : div_cnt + 16'd1;
      if (tick) tick_cnt <= tick_cnt + 4'd1;

      case (state)
        ST_IDLE: begin
          tick_cnt <= '0;
          if (!rxs) begin
            // Align the tick phase to the start edge.
            div_cnt <= '0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (tick && tick_cnt == 4'd7) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            state    <= rxs ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (sample_pt) begin
            byte_data[bit_idx] <= rxs;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample_pt) begin
            if (rxs) begin
              state <= ST_EMIT;
            end else begin
              frame_error <= 1'b1;
              state       <= ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: if (rxs) state <= ST_IDLE;
        ST_EMIT:      if (emit_done) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_receiver.sv
// uart_cmd_receiver: receives serial command bytes and drives the virtual
// input decoder with a command index and a strobe.
//   clk         - system clock, rising edge
//   rst_n       - synchronous active-low reset
//   rx          - asynchronous serial line, idles high
//   number      - decoder command index, stable between commands
//   control     - strobe, high PULSE_LEN cycles per accepted command
//   frame_error - one-cycle pulse on a low stop bit
//   cmd_error   - one-cycle pulse on a well-framed but illegal byte
module uart_cmd_receiver
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int PULSE_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [4:0] number,
  output logic       control,
  output logic       frame_error,
  output logic       cmd_error
);

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       emit_done;
  logic       strobe_pending;
  logic [3:0] pulse_cnt;

  // The receiver leaves EMIT when control falls, or right after a rejected byte.
  assign emit_done = cmd_error || (control && pulse_cnt == 4'd0);

  uart_rx_core #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_rx_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .emit_done  (emit_done),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_error(frame_error)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      number         <= CLEAR_NUMBER;
      control        <= 1'b0;
      cmd_error      <= 1'b0;
      strobe_pending <= 1'b0;
      pulse_cnt      <= '0;
    end else begin
      cmd_error      <= 1'b0;
      strobe_pending <= 1'b0;

      if (byte_valid) begin
        if (is_valid_cmd(byte_data)) begin
          number         <= (byte_data == CMD_CLEAR) ? CLEAR_NUMBER : byte_data[4:0];
          strobe_pending <= 1'b1;
        end else begin
          cmd_error <= 1'b1;
        end
      end

      // One cycle of setup on number before control rises.
      if (strobe_pending) begin
        control   <= 1'b1;
        pulse_cnt <= PULSE_LAST;
      end else if (control) begin
        if (pulse_cnt == 4'd0) control <= 1'b0;
        else pulse_cnt <= pulse_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_receiver.sv
module tb_uart_cmd_receiver;

  localparam int BIT_CYC = 432;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [4:0] number;
  logic       control;
  logic       frame_error;
  logic       cmd_error;

  int total = 0;
  int bad = 0;

  // Event monitor state (written only by the monitor process).
  int rises = 0, fe_pulses = 0, fe_cycles = 0, ce_pulses = 0, ce_cycles = 0;
  int num_changes = 0, num_in_ctrl = 0, both_err = 0;
  int since_num = 0, cur_len = 0, last_len = 0, rise_gap = 0;
  logic [4:0] rise_num = '0, prev_rise_num = '0, prev_number = '0;
  logic prev_control = 1'b0, prev_fe = 1'b0, prev_ce = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_receiver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .number     (number),
    .control    (control),
    .frame_error(frame_error),
    .cmd_error  (cmd_error)
  );

  always @(negedge clk) begin
    if (number !== prev_number) begin
      since_num = 0;
      num_changes++;
      if (control === 1'b1 || prev_control === 1'b1) num_in_ctrl++;
    end else begin
      since_num++;
    end
    if (control === 1'b1 && prev_control !== 1'b1) begin
      rises++;
      rise_gap      = since_num;
      prev_rise_num = rise_num;
      rise_num      = number;
      cur_len       = 1;
    end else if (control === 1'b1) begin
      cur_len++;
    end
    if (control !== 1'b1 && prev_control === 1'b1) last_len = cur_len;
    if (frame_error === 1'b1) fe_cycles++;
    if (frame_error === 1'b1 && prev_fe !== 1'b1) fe_pulses++;
    if (cmd_error === 1'b1) ce_cycles++;
    if (cmd_error === 1'b1 && prev_ce !== 1'b1) ce_pulses++;
    if (frame_error === 1'b1 && cmd_error === 1'b1) both_err++;
    prev_number  = number;
    prev_control = control;
    prev_fe      = frame_error;
    prev_ce      = cmd_error;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(BIT_CYC);
    end
    rx = stop_bit;
    cyc(BIT_CYC);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    int r0, f0, c0;
    rst_n = 1'b0;
    cyc(3);
    total++; if (number !== 5'd31) begin bad++; $display("FAIL reset_number: got %0d want 31", number); end
    total++; if (control !== 1'b0) begin bad++; $display("FAIL reset_control: got %b want 0", control); end
    total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
    total++; if (cmd_error !== 1'b0) begin bad++; $display("FAIL reset_cmd_error: got %b want 0", cmd_error); end
    rst_n = 1'b1;
    r0 = rises; f0 = fe_pulses; c0 = ce_pulses;
    cyc(10000);
    total++; if (rises - r0 !== 0) begin bad++; $display("FAIL idle_strobes: got %0d want 0", rises - r0); end
    total++; if (number !== 5'd31) begin bad++; $display("FAIL idle_number: got %0d want 31", number); end
    total++; if (f0 !== fe_pulses || c0 !== ce_pulses) begin bad++; $display("FAIL idle_errors: got fe=%0d ce=%0d want 0 0", fe_pulses - f0, ce_pulses - c0); end
  endtask

  task automatic test_single();
    int r0, f0, c0, n0;
    r0 = rises; f0 = fe_pulses; c0 = ce_pulses; n0 = num_in_ctrl;
    send_byte(8'h05, 1'b1);
    cyc(100);
    total++; if (rises - r0 !== 1) begin bad++; $display("FAIL single_strobes: got %0d want 1", rises - r0); end
    total++; if (last_len !== 4) begin bad++; $display("FAIL single_pulse_len: got %0d want 4", last_len); end
    total++; if (rise_gap !== 1) begin bad++; $display("FAIL single_setup: got %0d want 1", rise_gap); end
    total++; if (rise_num !== 5'd5) begin bad++; $display("FAIL single_rise_number: got %0d want 5", rise_num); end
    total++; if (number !== 5'd5) begin bad++; $display("FAIL single_number: got %0d want 5", number); end
    total++; if (fe_pulses != f0 || ce_pulses != c0) begin bad++; $display("FAIL single_errors: got fe=%0d ce=%0d want 0 0", fe_pulses - f0, ce_pulses - c0); end
    total++; if (num_in_ctrl != n0) begin bad++; $display("FAIL single_number_stable: got %0d want 0", num_in_ctrl - n0); end
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = rises;
    send_byte(8'h15, 1'b1);
    send_byte(8'h00, 1'b1);
    cyc(100);
    total++; if (rises - r0 !== 2) begin bad++; $display("FAIL b2b_strobes: got %0d want 2", rises - r0); end
    total++; if (prev_rise_num !== 5'd21) begin bad++; $display("FAIL b2b_first_number: got %0d want 21", prev_rise_num); end
    total++; if (rise_num !== 5'd0) begin bad++; $display("FAIL b2b_second_number: got %0d want 0", rise_num); end
    total++; if (number !== 5'd0) begin bad++; $display("FAIL b2b_number: got %0d want 0", number); end
    total++; if (last_len !== 4) begin bad++; $display("FAIL b2b_pulse_len: got %0d want 4", last_len); end
  endtask

  task automatic test_clear_and_illegal();
    int r0, c0, cc0, f0;
    r0 = rises;
    send_byte(8'h7F, 1'b1);
    cyc(100);
    total++; if (rises - r0 !== 1) begin bad++; $display("FAIL clear_strobes: got %0d want 1", rises - r0); end
    total++; if (number !== 5'd31) begin bad++; $display("FAIL clear_number: got %0d want 31", number); end
    total++; if (last_len !== 4) begin bad++; $display("FAIL clear_pulse_len: got %0d want 4", last_len); end
    r0 = rises; c0 = ce_pulses; cc0 = ce_cycles; f0 = fe_pulses;
    send_byte(8'h16, 1'b1);
    cyc(100);
    total++; if (ce_pulses - c0 !== 1) begin bad++; $display("FAIL illegal_cmd_error: got %0d want 1", ce_pulses - c0); end
    total++; if (ce_cycles - cc0 !== 1) begin bad++; $display("FAIL illegal_cmd_error_width: got %0d want 1", ce_cycles - cc0); end
    total++; if (rises - r0 !== 0) begin bad++; $display("FAIL illegal_strobes: got %0d want 0", rises - r0); end
    total++; if (number !== 5'd31) begin bad++; $display("FAIL illegal_number: got %0d want 31", number); end
    total++; if (fe_pulses - f0 !== 0) begin bad++; $display("FAIL illegal_frame_error: got %0d want 0", fe_pulses - f0); end
  endtask

  task automatic test_frame_error();
    int r0, f0, fc0, c0;
    r0 = rises; f0 = fe_pulses; fc0 = fe_cycles; c0 = ce_pulses;
    send_byte(8'h05, 1'b0);
    cyc(500);
    total++; if (fe_pulses - f0 !== 1) begin bad++; $display("FAIL frame_error_pulses: got %0d want 1", fe_pulses - f0); end
    total++; if (fe_cycles - fc0 !== 1) begin bad++; $display("FAIL frame_error_width: got %0d want 1", fe_cycles - fc0); end
    total++; if (rises - r0 !== 0) begin bad++; $display("FAIL frame_error_strobes: got %0d want 0", rises - r0); end
    total++; if (number !== 5'd31) begin bad++; $display("FAIL frame_error_number: got %0d want 31", number); end
    total++; if (ce_pulses - c0 !== 0) begin bad++; $display("FAIL frame_error_cmd_error: got %0d want 0", ce_pulses - c0); end
    r0 = rises;
    send_byte(8'h03, 1'b1);
    cyc(100);
    total++; if (number !== 5'd3) begin bad++; $display("FAIL recover_number: got %0d want 3", number); end
    total++; if (rises - r0 !== 1) begin bad++; $display("FAIL recover_strobes: got %0d want 1", rises - r0); end
  endtask

  task automatic test_glitch();
    int r0, f0, c0, n0;
    r0 = rises; f0 = fe_pulses; c0 = ce_pulses; n0 = num_changes;
    rx = 1'b0;
    cyc(100);
    rx = 1'b1;
    cyc(1000);
    total++; if (rises - r0 !== 0) begin bad++; $display("FAIL glitch_strobes: got %0d want 0", rises - r0); end
    total++; if (fe_pulses != f0 || ce_pulses != c0) begin bad++; $display("FAIL glitch_errors: got fe=%0d ce=%0d want 0 0", fe_pulses - f0, ce_pulses - c0); end
    total++; if (num_changes - n0 !== 0) begin bad++; $display("FAIL glitch_number_changes: got %0d want 0", num_changes - n0); end
  endtask

  task automatic test_reset_mid_byte();
    int r0, f0, c0;
    logic [7:0] b;
    b = 8'h0A;
    rx = 1'b0;
    cyc(BIT_CYC);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      cyc(BIT_CYC);
    end
    rx = b[3];
    cyc(200);
    rst_n = 1'b0;
    cyc(2);
    total++; if (number !== 5'd31) begin bad++; $display("FAIL midreset_number: got %0d want 31", number); end
    rst_n = 1'b1;
    rx = 1'b1;
    r0 = rises; f0 = fe_pulses; c0 = ce_pulses;
    cyc(5000);
    total++; if (rises - r0 !== 0) begin bad++; $display("FAIL midreset_strobes: got %0d want 0", rises - r0); end
    total++; if (fe_pulses != f0 || ce_pulses != c0) begin bad++; $display("FAIL midreset_errors: got fe=%0d ce=%0d want 0 0", fe_pulses - f0, ce_pulses - c0); end
    r0 = rises;
    send_byte(8'h0A, 1'b1);
    cyc(100);
    total++; if (number !== 5'd10) begin bad++; $display("FAIL after_reset_number: got %0d want 10", number); end
    total++; if (rises - r0 !== 1) begin bad++; $display("FAIL after_reset_strobes: got %0d want 1", rises - r0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clear_and_illegal();
    test_frame_error();
    test_glitch();
    test_reset_mid_byte();
    total++; if (both_err !== 0) begin bad++; $display("FAIL both_errors_same_cycle: got %0d want 0", both_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_receiver.md
Name: uart_cmd_receiver

Overview:
- Upstream feeder for the virtual-input decoder stage.
- Receives 8N1 serial command bytes from the host PC on the board RX pin and validates them.
- Drives the decoder's 5-bit `number` bus and `control` strobe, so each accepted command toggles exactly one virtual button or switch, or clears them all.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- OVERSAMPLE, 16, sample ticks per bit; fixed at 16.
- PULSE_LEN, 4, clk cycles that `control` is held high per accepted command (range 1..15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- rx  input  1  asynchronous serial line; idles high.
- number  output  5  command index to the decoder; held stable between commands.
- control  output  1  command strobe; rising edge consumed by the decoder.
- frame_error  output  1  one-cycle pulse when the stop bit samples low.
- cmd_error  output  1  one-cycle pulse when a well-framed byte is not a legal command.

Behaviour:
- Reset (rst_n low at a clk edge):
  - number=5'b11111; control=0; frame_error=0; cmd_error=0.
  - FSM=IDLE; all counters cleared.
  - Reset mid-byte abandons the byte with no strobe.
- rx synchronizer: 2-flop chain. All logic uses the synchronized value rxs.
- Tick generator: divider DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer floor (27 at defaults). It emits a one-cycle tick when the count reaches DIV-1 and then wraps to 0. The divider free-runs, but is restarted on the IDLE->START transition.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH, EMIT.
  - IDLE: rxs==0 -> START; tick count=0.
  - START: after 8 ticks (mid-bit), resample.
    - rxs==0 -> DATA; bit index=0.
    - rxs==1 -> IDLE (glitch rejection; no error).
  - DATA: every 16 ticks, sample rxs into shift[bit index]. Bits are LSB first. After bit 7 -> STOP.
  - STOP: after 16 ticks, sample rxs.
    - rxs==1 -> EMIT.
    - rxs==0 -> pulse frame_error, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then -> IDLE.
  - EMIT: classify the byte in the first EMIT cycle.
    - Byte 0x00..0x15: number<=byte[4:0].
    - Byte 0x7F (clear-all): number<=5'b11111. The decoder's out-of-range index resets all outputs.
    - Any other byte: pulse cmd_error for one cycle, leave number unchanged, -> IDLE with no strobe.
  - Strobe timing for accepted commands:
    - number updates in cycle E.
    - control rises in cycle E+1, giving one cycle of setup on number before the decoder's clock edge.
    - control holds for PULSE_LEN cycles, then falls.
    - FSM returns to IDLE on the cycle control falls.
- Latency: control rises 2 clk cycles after the stop-bit sample tick.
- number never changes while control is high.
- A new start bit arriving while in EMIT is not lost: the FSM ignores rx only until it reaches IDLE. PULSE_LEN<=15 cycles is far shorter than the 8-tick start window.
- frame_error and cmd_error are never asserted in the same cycle.
- Back-to-back bytes with a one-bit stop period must all be accepted.

Decomposition:
- Package uart_cmd_pkg:
  - FSM state enum.
  - CMD_MAX_INDEX=8'h15; CMD_CLEAR=8'h7F; CLEAR_NUMBER=5'b11111.
  - Function is_valid_cmd(byte).
- Sub-module uart_rx_core: synchronizer, tick divider and the START/DATA/STOP/WAIT_HIGH states. It outputs byte_valid (1 cycle), byte_data[7:0] and frame_error.
- Top level: EMIT classification, number register and control pulse counter.

Test Plan:
- Idle line, rst_n pulsed -> number=31, control=0, both error flags 0, with no edges for 10000 cycles.
- Send 0x05 at 50 MHz / 27-cycle tick (432 cycles per bit) -> number=5 and stable; control high exactly 4 cycles, rising one cycle after number changes; no error pulse.
- Send 0x15, then 0x00 back-to-back with a single stop bit -> two strobes, with number=21 then number=0.
- Send 0x7F -> number=31 plus one 4-cycle control pulse. Send 0x16 -> one-cycle cmd_error, number unchanged, control stays 0.
- Send 0x05 with the stop bit forced low, then line high -> one-cycle frame_error, no strobe; a following 0x03 is received normally (number=3).
- 100-cycle low glitch on rx -> back to IDLE, no outputs change. Separately, assert rst_n low during DATA of byte 0x0A -> no strobe, number=31; the next 0x0A byte is accepted.
